// File: rtl/quad_encoder_emulator.sv
// Bouncy two-phase quadrature generator driven by clean step commands.
// Define QENC_BOUNCE_EN to enable LFSR-timed contact bounce; otherwise each step is one clean toggle.
module quad_encoder_emulator #(
  parameter int          BOUNCE_COUNT  = 3,
  parameter int          SEG_WIDTH     = 3,
  parameter int          SETTLE_CYCLES = 16,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step_valid,
  input  logic       step_dir,
  output logic       step_ready,
  output logic       busy,
  output logic       enc_a,
  output logic       enc_b,
  output logic [7:0] position
);

  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_CYCLES - 1);

  generate
    if (SETTLE_CYCLES < 1 || SEG_WIDTH < 1 || SEG_WIDTH > 16 ||
        BOUNCE_COUNT < 0 || LFSR_SEED == 16'h0000) begin : g_bad_params
      $error("quad_encoder_emulator: illegal parameter value");
    end
  endgenerate

`ifdef QENC_BOUNCE_EN
  localparam int BLW = (BOUNCE_COUNT > 0) ? $clog2(2 * BOUNCE_COUNT + 1) : 1;
  localparam logic [BLW-1:0] BOUNCE_LOAD = BLW'(2 * BOUNCE_COUNT);

  typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

  logic [15:0]          lfsr_q;
  logic [15:0]          lfsr_d;
  logic [SEG_WIDTH-1:0] seg_cnt_q;
  logic [SEG_WIDTH-1:0] seg_load_d;
  logic [BLW-1:0]       bounce_left_q;
  logic                 tgt_a_q;

  assign lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign seg_load_d = lfsr_q[SEG_WIDTH-1:0];
`else
  typedef enum logic [1:0] {IDLE, SETTLE} state_t;
`endif

  state_t         state_q;
  logic           enc_a_q;
  logic           enc_b_q;
  logic [7:0]     position_q;
  logic [SCW-1:0] settle_cnt_q;
  logic           tgt_a_d;

  // Gray sequence: line A moves when A^B matches the direction, else line B.
  assign tgt_a_d = enc_a_q ^ enc_b_q ^ step_dir;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      enc_a_q       <= 1'b0;
      enc_b_q       <= 1'b0;
      position_q    <= '0;
      settle_cnt_q  <= '0;
`ifdef QENC_BOUNCE_EN
      lfsr_q        <= LFSR_SEED;
      seg_cnt_q     <= '0;
      bounce_left_q <= '0;
      tgt_a_q       <= 1'b0;
`endif
    end else begin
`ifdef QENC_BOUNCE_EN
      lfsr_q <= lfsr_d;
`endif
      case (state_q)
        IDLE: begin
          if (step_valid) begin
            if (tgt_a_d) enc_a_q <= ~enc_a_q;
            else         enc_b_q <= ~enc_b_q;
            position_q <= step_dir ? position_q + 8'd1 : position_q - 8'd1;
`ifdef QENC_BOUNCE_EN
            tgt_a_q       <= tgt_a_d;
            bounce_left_q <= BOUNCE_LOAD;
            seg_cnt_q     <= seg_load_d;
            if (BOUNCE_COUNT > 0) begin
              state_q <= BOUNCE;
            end else begin
              state_q      <= SETTLE;
              settle_cnt_q <= SETTLE_LOAD;
            end
`else
            state_q      <= SETTLE;
            settle_cnt_q <= SETTLE_LOAD;
`endif
          end
        end
`ifdef QENC_BOUNCE_EN
        BOUNCE: begin
          if (seg_cnt_q == '0) begin
            if (tgt_a_q) enc_a_q <= ~enc_a_q;
            else         enc_b_q <= ~enc_b_q;
            bounce_left_q <= bounce_left_q - BLW'(1);
            seg_cnt_q     <= seg_load_d;
            if (bounce_left_q == BLW'(1)) begin
              state_q      <= SETTLE;
              settle_cnt_q <= SETTLE_LOAD;
            end
          end else begin
            seg_cnt_q <= seg_cnt_q - SEG_WIDTH'(1);
          end
        end
`endif
        SETTLE: begin
          if (settle_cnt_q == '0) state_q <= IDLE;
          else                    settle_cnt_q <= settle_cnt_q - SCW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign step_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign enc_a      = enc_a_q;
  assign enc_b      = enc_b_q;
  assign position   = position_q;

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Directed self-checking bench for quad_encoder_emulator (default parameters).
// Expectations follow QENC_BOUNCE_EN when it is defined for the build.
module tb_quad_encoder_emulator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       step_valid = 1'b0;
  logic       step_dir = 1'b0;
  logic       step_ready;
  logic       busy;
  logic       enc_a;
  logic       enc_b;
  logic [7:0] position;

  int checks = 0;
  int failures = 0;

  quad_encoder_emulator dut (
    .clk        (clk),
    .reset      (reset),
    .step_valid (step_valid),
    .step_dir   (step_dir),
    .step_ready (step_ready),
    .busy       (busy),
    .enc_a      (enc_a),
    .enc_b      (enc_b),
    .position   (position)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] next_phase(input logic [1:0] p, input logic up);
    case (p)
      2'b00:   return up ? 2'b10 : 2'b01;
      2'b10:   return up ? 2'b11 : 2'b00;
      2'b11:   return up ? 2'b01 : 2'b10;
      default: return up ? 2'b00 : 2'b11;
    endcase
  endfunction

  // One step; returns busy samples, toggles per line, and stable run ending the step.
  task automatic do_step(input logic dir, output int bcyc, output int ta, output int tb,
                         output int run);
    int   guard;
    logic pa, pb;
    guard = 0;
    @(negedge clk);
    while (!step_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_step", step_ready, 1);
    pa = enc_a;
    pb = enc_b;
    step_valid = 1'b1;
    step_dir   = dir;
    @(posedge clk);
    #1;
    step_valid = 1'b0;
    step_dir   = ~dir;
    ta = 0; tb = 0; bcyc = 0; run = 0; guard = 0;
    while (busy && guard < 1000) begin
      if (enc_a != pa) ta++;
      if (enc_b != pb) tb++;
      if (enc_a != pa || enc_b != pb) run = 1;
      else run++;
      pa = enc_a;
      pb = enc_b;
      bcyc++;
      @(posedge clk);
      #1;
      guard++;
    end
    check("step_finished", busy, 0);
  endtask

  task automatic check_step_len(input string tag, input int bcyc);
`ifdef QENC_BOUNCE_EN
    check(tag, (bcyc >= 22 && bcyc <= 64), 1);
`else
    check(tag, bcyc, 16);
`endif
  endtask

  int         bcyc, ta, tb, run, acc;
  logic [1:0] phase_tbl [3];
  logic [7:0] exp_pos;
  logic [1:0] exp_ph;
  logic       rdy, d;

  initial begin
    phase_tbl[0] = 2'b11;
    phase_tbl[1] = 2'b01;
    phase_tbl[2] = 2'b00;

    // Power-on reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_enc_a", enc_a, 0);
    check("rst_enc_b", enc_b, 0);
    check("rst_position", position, 8'h00);
    check("rst_ready", step_ready, 1);
    check("rst_busy", busy, 0);

    // Single up step
    do_step(1'b1, bcyc, ta, tb, run);
`ifdef QENC_BOUNCE_EN
    check("up_toggles_a", ta, 7);
`else
    check("up_toggles_a", ta, 1);
`endif
    check("up_toggles_b", tb, 0);
    check("up_phase", {enc_a, enc_b}, 2'b10);
    check("up_settle_run", run, 16);
    check("up_position", position, 8'h01);
    check_step_len("up_busy_len", bcyc);

    // Remaining three steps of a full up cycle, back-to-back
    for (int i = 0; i < 3; i++) begin
      do_step(1'b1, bcyc, ta, tb, run);
      check("seq_phase", {enc_a, enc_b}, phase_tbl[i]);
      check("seq_one_line", (ta == 0) || (tb == 0), 1);
      check("seq_odd_toggles", (ta + tb) % 2, 1);
      check_step_len("seq_busy_len", bcyc);
    end
    check("seq_position", position, 8'h04);

    // Reset shortly after an accept aborts the step without a clock edge
    @(negedge clk);
    step_valid = 1'b1;
    step_dir   = 1'b1;
    @(posedge clk);
    #1;
    step_valid = 1'b0;
    check("pre_abort_busy", busy, 1);
    check("pre_abort_position", position, 8'h05);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_enc_a", enc_a, 0);
    check("abort_enc_b", enc_b, 0);
    check("abort_position", position, 8'h00);
    check("abort_ready", step_ready, 1);
    @(negedge clk);
    reset = 1'b0;

    // Down from reset, then wrap through 8'h7F -> 8'h80
    do_step(1'b0, bcyc, ta, tb, run);
    check("down_phase", {enc_a, enc_b}, 2'b01);
    check("down_toggles_a", ta, 0);
    check("down_position", position, 8'hFF);
    check_step_len("down_busy_len", bcyc);
    for (int i = 0; i < 128; i++) do_step(1'b1, bcyc, ta, tb, run);
    check("wrap_pos_7f", position, 8'h7F);
    check("wrap_phase_7f", {enc_a, enc_b}, 2'b01);
    do_step(1'b1, bcyc, ta, tb, run);
    check("wrap_pos_80", position, 8'h80);
    check("wrap_phase_80", {enc_a, enc_b}, 2'b00);

    // step_valid held high, step_dir flipping every cycle
    exp_pos = 8'h80;
    exp_ph  = 2'b00;
    acc     = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      step_valid = 1'b1;
      step_dir   = ~step_dir;
      rdy = step_ready;
      d   = step_dir;
      @(posedge clk);
      #1;
      if (rdy) begin
        acc++;
        exp_pos = d ? exp_pos + 8'd1 : exp_pos - 8'd1;
        exp_ph  = next_phase(exp_ph, d);
        check("hold_phase", {enc_a, enc_b}, exp_ph);
        check("hold_busy_after_accept", busy, 1);
      end
      check("hold_position", position, exp_pos);
    end
    step_valid = 1'b0;
    check("hold_accept_count", acc >= 4, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
